// File: rtl/ni_inj_pkg.sv
// Shared definitions for the network-interface flit injector: a width helper,
// the flit header field offsets and the framing FSM state type.
package ni_inj_pkg;

    // Ceiling log2 with a floor of 1 bit, so that log2(n) bits can hold 0 .. n-1.
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Header positions are counted down from the flit width (bit Fw-HEAD_BIT is
    // head, bit Fw-TAIL_BIT is tail). The one-hot VC field starts VC_LSB bits
    // above the top of the payload.
    localparam int HEAD_BIT = 1;
    localparam int TAIL_BIT = 2;
    localparam int VC_LSB   = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_e;

endpackage

// File: rtl/ni_vc_rr_arbiter.sv
// Round-robin one-hot arbiter over the downstream VCs. The priority register
// holds the VC to try first and moves one above the winner, but only when a
// head flit is actually granted. Needs V >= 2.
module ni_vc_rr_arbiter #(
    parameter int V = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [V-1:0] req,
    input  logic         advance,
    output logic [V-1:0] grant
);

    localparam logic [V-1:0] ONE = V'(1);

    logic [V-1:0] prio;
    logic [V-1:0] req_hi;
    logic [V-1:0] grant_hi;
    logic [V-1:0] grant_lo;

    // Lowest requester at or above the priority bit wins; otherwise wrap to the lowest overall.
    always_comb begin
        req_hi   = req & ~(prio - ONE);
        grant_hi = req_hi & (~req_hi + ONE);
        grant_lo = req & (~req + ONE);
        grant    = (|req_hi) ? grant_hi : grant_lo;
    end

    // Rotate priority to one above the granted VC when a head is taken.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values; blocking here would create ordering-dependent races.
        if (reset) begin
            prio <= ONE;
        end else if (advance && (|grant)) begin
            prio <= {grant[V-2:0], grant[V-1]};
        end
    end

endmodule

// File: rtl/ni_flit_injector.sv
// Local-port flit injector: frames a payload-beat stream into head/body/tail
// flits on one downstream VC per packet and tracks per-VC credits returned by
// the router. One packet in flight at a time.
// Optional build macro NI_INJ_CREDIT_CHK_EN adds a sticky credit_err output
// flagging credit overflow/underflow; without it counters saturate at B.
module ni_flit_injector
    import ni_inj_pkg::*;
#(
    parameter int    V                    = 4,
    parameter int    B                    = 4,
    parameter int    Fpay                 = 32,
    parameter string VC_REALLOCATION_TYPE = "NONATOMIC",
    parameter int    Fw                   = 2 + V + Fpay
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pay_valid,
    input  logic [Fpay-1:0] pay_data,
    input  logic            pay_last,
    output logic            pay_ready,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_we,
    input  logic [V-1:0]    credit_in,
    output logic [V-1:0]    cur_vc,
    output logic            busy
`ifdef NI_INJ_CREDIT_CHK_EN
    ,
    output logic            credit_err
`endif
);

    localparam int             CW       = log2(B + 1);
    localparam logic [CW-1:0]  B_CNT    = CW'(B);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam bit             ATOMIC   = (VC_REALLOCATION_TYPE == "ATOMIC");
    localparam int             HEAD_POS = Fw - HEAD_BIT;
    localparam int             TAIL_POS = Fw - TAIL_BIT;
    localparam int             VC_POS   = Fpay + VC_LSB;

    inj_state_e    state;
    inj_state_e    state_n;
    logic [V-1:0]  cur_vc_n;

    logic [CW-1:0] cnt   [V];
    logic [CW-1:0] cnt_n [V];

    logic [V-1:0]  has_credit;
    logic [V-1:0]  eligible;
    logic [V-1:0]  grant;
    logic [V-1:0]  send_vc;
    logic [V-1:0]  dec;
    logic          cur_has_credit;
    logic          accept;
    logic          head_accept;
    logic [Fw-1:0] flit_d;

    // Per-VC credit status and eligibility of each VC to carry a new head.
    always_comb begin
        has_credit = '0;
        eligible   = '0;
        for (int v = 0; v < V; v++) begin
            has_credit[v] = (cnt[v] != '0);
            eligible[v]   = ATOMIC ? (cnt[v] == B_CNT) : has_credit[v];
        end
    end

    // Handshake: ready depends only on registered state, never on pay_valid.
    always_comb begin
        cur_has_credit = |(cur_vc & has_credit);
        pay_ready      = (state == IDLE) ? (|eligible) : cur_has_credit;
        accept         = pay_valid && pay_ready;
        head_accept    = accept && (state == IDLE);
        send_vc        = (state == IDLE) ? grant : cur_vc;
        dec            = accept ? send_vc : '0;
        busy           = (state == SEND);
    end

    ni_vc_rr_arbiter #(
        .V (V)
    ) u_vc_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (head_accept),
        .grant   (grant)
    );

    // Framing FSM next-state: open a packet on a multi-beat head, close it on the tail.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_n  = state;
        cur_vc_n = cur_vc;
        case (state)
            IDLE: begin
                if (accept && !pay_last) begin
                    state_n  = SEND;
                    cur_vc_n = grant;
                end
            end
            SEND: begin
                if (accept && pay_last) begin
                    state_n  = IDLE;
                    cur_vc_n = '0;
                end
            end
            default: begin
                state_n  = IDLE;
                cur_vc_n = '0;
            end
        endcase
    end

    // FSM state and the VC of the packet in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cur_vc <= '0;
        end else begin
            state  <= state_n;
            cur_vc <= cur_vc_n;
        end
    end

    // Credit arithmetic: +1 per returned credit, -1 per flit sent, saturating at B.
    always_comb begin
        for (int v = 0; v < V; v++) begin
            cnt_n[v] = cnt[v];
            if (credit_in[v] && !dec[v]) begin
                if (cnt[v] != B_CNT) cnt_n[v] = cnt[v] + CNT_ONE;
            end else if (dec[v] && !credit_in[v]) begin
                if (cnt[v] != '0) cnt_n[v] = cnt[v] - CNT_ONE;
            end
        end
    end

    // Credit counters, all restored to the full buffer depth on reset.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly because it is
        // flow-control state; it is not a RAM and must never start unknown.
        if (reset) begin
            for (int v = 0; v < V; v++) cnt[v] <= B_CNT;
        end else begin
            for (int v = 0; v < V; v++) cnt[v] <= cnt_n[v];
        end
    end

    // Assemble the outgoing flit from the accepted beat.
    always_comb begin
        flit_d                = '0;
        flit_d[HEAD_POS]      = (state == IDLE);
        flit_d[TAIL_POS]      = pay_last;
        flit_d[VC_POS +: V]   = send_vc;
        flit_d[Fpay-1:0]      = pay_data;
    end

    // Output flit register: strobe for one cycle per accepted beat, hold data otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out    <= '0;
            flit_out_we <= 1'b0;
        end else begin
            flit_out_we <= accept;
            if (accept) flit_out <= flit_d;
        end
    end

`ifdef NI_INJ_CREDIT_CHK_EN
    logic credit_fault;

    // Detect a credit beyond the buffer depth or a send with no credit left.
    always_comb begin
        credit_fault = 1'b0;
        for (int v = 0; v < V; v++) begin
            if ((credit_in[v] && !dec[v] && (cnt[v] == B_CNT)) ||
                (dec[v] && !credit_in[v] && (cnt[v] == '0))) begin
                credit_fault = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_err <= 1'b0;
        end else if (credit_fault) begin
            credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
// Self-checking bench for ni_flit_injector: one NONATOMIC and one ATOMIC
// instance share stimulus. Directed tables cover the framing, credit-stall,
// same-cycle credit and reset cases; a randomized phase compares both
// instances against a packet-level reference model.
module tb_ni_flit_injector;

    localparam int V    = 4;
    localparam int B    = 4;
    localparam int FPAY = 32;
    localparam int FW   = 2 + V + FPAY;

    logic            clk = 1'b0;
    logic            reset;
    logic            pay_valid;
    logic [FPAY-1:0] pay_data;
    logic            pay_last;
    logic [V-1:0]    credit_in;

    logic [1:0]           rdy;
    logic [1:0][FW-1:0]   flit;
    logic [1:0]           we;
    logic [1:0][V-1:0]    cur;
    logic [1:0]           bsy;
`ifdef NI_INJ_CREDIT_CHK_EN
    logic [1:0]           err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ni_flit_injector #(
        .V (V), .B (B), .Fpay (FPAY), .VC_REALLOCATION_TYPE ("NONATOMIC")
    ) u_nonatomic (
        .clk (clk), .reset (reset),
        .pay_valid (pay_valid), .pay_data (pay_data), .pay_last (pay_last),
        .pay_ready (rdy[0]), .flit_out (flit[0]), .flit_out_we (we[0]),
        .credit_in (credit_in), .cur_vc (cur[0]), .busy (bsy[0])
`ifdef NI_INJ_CREDIT_CHK_EN
        , .credit_err (err[0])
`endif
    );

    ni_flit_injector #(
        .V (V), .B (B), .Fpay (FPAY), .VC_REALLOCATION_TYPE ("ATOMIC")
    ) u_atomic (
        .clk (clk), .reset (reset),
        .pay_valid (pay_valid), .pay_data (pay_data), .pay_last (pay_last),
        .pay_ready (rdy[1]), .flit_out (flit[1]), .flit_out_we (we[1]),
        .credit_in (credit_in), .cur_vc (cur[1]), .busy (bsy[1])
`ifdef NI_INJ_CREDIT_CHK_EN
        , .credit_err (err[1])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                         input logic [V-1:0] vc, input logic [FPAY-1:0] d);
        return {h, t, vc, d};
    endfunction

    typedef struct {
        logic            rst;
        logic            valid;
        logic [FPAY-1:0] data;
        logic            last;
        logic [V-1:0]    ci;
        logic            exp_ready;
        logic            exp_we;
        logic [FW-1:0]   exp_flit;
        logic            exp_busy;
        logic [V-1:0]    exp_cur;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic valid, input logic [FPAY-1:0] data,
                                 input logic last, input logic [V-1:0] ci, input logic exp_ready,
                                 input logic exp_we, input logic [FW-1:0] exp_flit,
                                 input logic exp_busy, input logic [V-1:0] exp_cur);
        vec_t t;
        t.rst = rst; t.valid = valid; t.data = data; t.last = last; t.ci = ci;
        t.exp_ready = exp_ready; t.exp_we = exp_we; t.exp_flit = exp_flit;
        t.exp_busy = exp_busy; t.exp_cur = exp_cur;
        return t;
    endfunction

    // Apply one vector (entered at posedge+1) and compare instance k's outputs.
    task automatic run_vec(input int k, input vec_t t, input string tag);
        reset = t.rst; pay_valid = t.valid; pay_data = t.data;
        pay_last = t.last; credit_in = t.ci;
        #1;
        check({tag, " pay_ready"}, 64'(rdy[k]), 64'(t.exp_ready));
        @(posedge clk); #1;
        check({tag, " flit_out_we"}, 64'(we[k]), 64'(t.exp_we));
        check({tag, " flit_out"}, 64'(flit[k]), 64'(t.exp_flit));
        check({tag, " busy"}, 64'(bsy[k]), 64'(t.exp_busy));
        check({tag, " cur_vc"}, 64'(cur[k]), 64'(t.exp_cur));
    endtask

    task automatic do_reset();
        reset = 1'b1; pay_valid = 1'b0; pay_last = 1'b0; pay_data = '0; credit_in = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model (packet level) ----------------
    int            m_cred  [2][V];
    bit            m_inpkt [2];
    int            m_cur   [2];
    int            m_rr    [2];
    logic [FW-1:0] m_flit  [2];
    bit            m_we    [2];
    bit            m_err   [2];

    function automatic void m_reset_one(input int k);
        for (int v = 0; v < V; v++) m_cred[k][v] = B;
        m_inpkt[k] = 0; m_cur[k] = 0; m_rr[k] = 0;
        m_flit[k] = '0; m_we[k] = 0; m_err[k] = 0;
    endfunction

    function automatic bit m_elig(input int k, input int v);
        if (k == 1) return m_cred[k][v] == B;
        return m_cred[k][v] > 0;
    endfunction

    function automatic bit m_ready(input int k);
        if (m_inpkt[k]) return m_cred[k][m_cur[k]] > 0;
        for (int v = 0; v < V; v++) if (m_elig(k, v)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [V-1:0] onehot(input int v);
        logic [V-1:0] oh;
        oh = '0;
        oh[v] = 1'b1;
        return oh;
    endfunction

    // Advance instance k's model by one clock using the currently driven inputs.
    function automatic void m_step(input int k);
        bit acc;
        int vc;
        logic head;
        if (reset) begin
            m_reset_one(k);
            return;
        end
        acc  = pay_valid && m_ready(k);
        vc   = -1;
        head = 1'b0;
        if (acc) begin
            if (!m_inpkt[k]) begin
                for (int i = 0; i < V; i++) begin
                    int c;
                    c = (m_rr[k] + i) % V;
                    if (m_elig(k, c)) begin
                        vc = c;
                        break;
                    end
                end
                m_rr[k] = (vc + 1) % V;
                head = 1'b1;
            end else begin
                vc = m_cur[k];
            end
            m_flit[k]  = mk(head, pay_last, onehot(vc), pay_data);
            m_inpkt[k] = !pay_last;
            m_cur[k]   = vc;
        end
        m_we[k] = acc;
        for (int v = 0; v < V; v++) begin
            bit sent;
            sent = acc && (vc == v);
            if (credit_in[v] && !sent) begin
                if (m_cred[k][v] == B) m_err[k] = 1;
                else m_cred[k][v]++;
            end else if (sent && !credit_in[v]) begin
                m_cred[k][v]--;
            end
        end
    endfunction

    vec_t na_tab[$];
    vec_t at_tab[$];

    initial begin
        reset = 1'b1; pay_valid = 1'b0; pay_last = 1'b0; pay_data = '0; credit_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("inst%0d reset pay_ready", k), 64'(rdy[k]), 64'(1));
            check($sformatf("inst%0d reset flit_out_we", k), 64'(we[k]), 64'(0));
            check($sformatf("inst%0d reset flit_out", k), 64'(flit[k]), 64'(0));
            check($sformatf("inst%0d reset busy", k), 64'(bsy[k]), 64'(0));
            check($sformatf("inst%0d reset cur_vc", k), 64'(cur[k]), 64'(0));
`ifdef NI_INJ_CREDIT_CHK_EN
            check($sformatf("inst%0d reset credit_err", k), 64'(err[k]), 64'(0));
`endif
        end

        // NONATOMIC directed table: rst valid data last ci | ready we flit busy cur
        // 3-beat packet on VC0, then single-beat packets rotating to VC1, VC2.
        na_tab.push_back(mkv(0,1,'hA,0,4'b0000, 1,1,mk(1,0,4'b0001,'hA),1,4'b0001));
        na_tab.push_back(mkv(0,1,'hB,0,4'b0000, 1,1,mk(0,0,4'b0001,'hB),1,4'b0001));
        na_tab.push_back(mkv(0,1,'hC,1,4'b0000, 1,1,mk(0,1,4'b0001,'hC),0,4'b0000));
        na_tab.push_back(mkv(0,1,'hD,1,4'b0000, 1,1,mk(1,1,4'b0010,'hD),0,4'b0000));
        na_tab.push_back(mkv(0,1,'hE,1,4'b0000, 1,1,mk(1,1,4'b0100,'hE),0,4'b0000));
        na_tab.push_back(mkv(0,0,'h0,0,4'b0000, 1,0,mk(1,1,4'b0100,'hE),0,4'b0000));
        // Reset, then exhaust VC0 credits: ready drops after the 4th beat.
        na_tab.push_back(mkv(1,0,'h0,0,4'b0000, 1,0,'0,0,4'b0000));
        na_tab.push_back(mkv(0,1,'h1,0,4'b0000, 1,1,mk(1,0,4'b0001,'h1),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h2,0,4'b0000, 1,1,mk(0,0,4'b0001,'h2),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h3,0,4'b0000, 1,1,mk(0,0,4'b0001,'h3),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h4,0,4'b0000, 1,1,mk(0,0,4'b0001,'h4),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h5,0,4'b0000, 0,0,mk(0,0,4'b0001,'h4),1,4'b0001));
        // One credit returned: exactly one more flit, the cycle after acceptance.
        na_tab.push_back(mkv(0,1,'h5,0,4'b0001, 0,0,mk(0,0,4'b0001,'h4),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h5,0,4'b0000, 1,1,mk(0,0,4'b0001,'h5),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h6,1,4'b0000, 0,0,mk(0,0,4'b0001,'h5),1,4'b0001));
        // Reset while stalled mid-packet, then reset after 2 of 5 beats.
        na_tab.push_back(mkv(1,1,'h6,1,4'b0000, 0,0,'0,0,4'b0000));
        na_tab.push_back(mkv(0,1,'h7,0,4'b0000, 1,1,mk(1,0,4'b0001,'h7),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h8,0,4'b0000, 1,1,mk(0,0,4'b0001,'h8),1,4'b0001));
        na_tab.push_back(mkv(1,1,'h9,0,4'b0000, 1,0,'0,0,4'b0000));
        na_tab.push_back(mkv(0,1,'h10,1,4'b0000, 1,1,mk(1,1,4'b0001,'h10),0,4'b0000));
        // Same-cycle return and send on VC0 at cnt=2: five beats fit before the stall.
        na_tab.push_back(mkv(1,0,'h0,0,4'b0000, 1,0,'0,0,4'b0000));
        na_tab.push_back(mkv(0,1,'h21,0,4'b0000, 1,1,mk(1,0,4'b0001,'h21),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h22,0,4'b0000, 1,1,mk(0,0,4'b0001,'h22),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h23,0,4'b0001, 1,1,mk(0,0,4'b0001,'h23),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h24,0,4'b0000, 1,1,mk(0,0,4'b0001,'h24),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h25,0,4'b0000, 1,1,mk(0,0,4'b0001,'h25),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h26,1,4'b0000, 0,0,mk(0,0,4'b0001,'h25),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h26,1,4'b0001, 0,0,mk(0,0,4'b0001,'h25),1,4'b0001));
        na_tab.push_back(mkv(0,1,'h26,1,4'b0000, 1,1,mk(0,1,4'b0001,'h26),0,4'b0000));
        na_tab.push_back(mkv(0,0,'h0,0,4'b0000, 1,0,mk(0,1,4'b0001,'h26),0,4'b0000));

        // ATOMIC directed table, applied after a fresh reset.
        at_tab.push_back(mkv(0,1,'h1,1,4'b0000, 1,1,mk(1,1,4'b0001,'h1),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h2,1,4'b0000, 1,1,mk(1,1,4'b0010,'h2),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h3,1,4'b0000, 1,1,mk(1,1,4'b0100,'h3),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h4,1,4'b0000, 1,1,mk(1,1,4'b1000,'h4),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h5,1,4'b0000, 0,0,mk(1,1,4'b1000,'h4),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h5,1,4'b1110, 0,0,mk(1,1,4'b1000,'h4),0,4'b0000));
        at_tab.push_back(mkv(0,1,'h5,1,4'b0000, 1,1,mk(1,1,4'b0010,'h5),0,4'b0000));
        at_tab.push_back(mkv(0,0,'h0,0,4'b0000, 1,0,mk(1,1,4'b0010,'h5),0,4'b0000));

        for (int i = 0; i < na_tab.size(); i++)
            run_vec(0, na_tab[i], $sformatf("nonatomic row%0d", i));

        do_reset();
        for (int i = 0; i < at_tab.size(); i++)
            run_vec(1, at_tab[i], $sformatf("atomic row%0d", i));

`ifdef NI_INJ_CREDIT_CHK_EN
        // Spurious credit on a full VC sets the sticky error flag.
        do_reset();
        credit_in = 4'b0100;
        @(posedge clk); #1;
        credit_in = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("inst%0d credit_err sticky", k), 64'(err[k]), 64'(1));
`endif

        // Randomized phase against the reference model.
        do_reset();
        for (int k = 0; k < 2; k++) m_reset_one(k);
        for (int n = 0; n < 2000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            pay_valid = ($urandom_range(0, 3) != 0);
            pay_data  = $urandom;
            pay_last  = ($urandom_range(0, 3) == 0);
            for (int v = 0; v < V; v++) credit_in[v] = ($urandom_range(0, 5) == 0);
            #1;
            for (int k = 0; k < 2; k++)
                check($sformatf("rand%0d inst%0d pay_ready", n, k), 64'(rdy[k]), 64'(m_ready(k)));
            for (int k = 0; k < 2; k++) m_step(k);
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rand%0d inst%0d flit_out_we", n, k), 64'(we[k]), 64'(m_we[k]));
                check($sformatf("rand%0d inst%0d flit_out", n, k), 64'(flit[k]), 64'(m_flit[k]));
                check($sformatf("rand%0d inst%0d busy", n, k), 64'(bsy[k]), 64'(m_inpkt[k]));
                check($sformatf("rand%0d inst%0d cur_vc", n, k), 64'(cur[k]),
                      64'(m_inpkt[k] ? onehot(m_cur[k]) : 4'b0000));
`ifdef NI_INJ_CREDIT_CHK_EN
                check($sformatf("rand%0d inst%0d credit_err", n, k), 64'(err[k]), 64'(m_err[k]));
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_flit_injector.md
# ni_flit_injector

Local-port transmitter that feeds one router input port. It accepts a payload-beat stream from the network interface and frames it into head/body/tail flits. Each packet gets an input VC of the downstream router, and the block tracks per-VC credits returned by the router. It drives the router's `flit_in`/`flit_in_we` pair for its port and consumes the matching `credit_out` bits, closing the credit loop from the sender side.

## Interface
Parameters:
- `V`, 4: VCs per port; width of `credit_in` and of the one-hot VC field.
- `B`, 4: flit buffer depth per VC in the router; initial credit count.
- `Fpay`, 32: payload bits per flit.
- `VC_REALLOCATION_TYPE`, "NONATOMIC": "ATOMIC" or "NONATOMIC"; the VC eligibility rule for a new head.
- `Fw`, 2+V+Fpay: derived; not overridden.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pay_valid`, in, 1: payload beat offered.
- `pay_data`, in, Fpay: payload of the beat.
- `pay_last`, in, 1: beat is the last of its packet.
- `pay_ready`, out, 1: beat accepted this cycle when high together with `pay_valid`.
- `flit_out`, out, Fw: flit to router. Bit Fw-1 is head, bit Fw-2 is tail, bits [Fw-3:Fpay] are the one-hot VC, bits [Fpay-1:0] are the payload.
- `flit_out_we`, out, 1: flit write strobe.
- `credit_in`, in, V: one credit per asserted bit, per VC.
- `cur_vc`, out, V: one-hot VC of the packet in progress; 0 when idle.
- `busy`, out, 1: high while state is SEND.

## Operation
- Per-VC credit counter, width log2(B+1), reset to B.
- FSM states:
  - IDLE: if `pay_valid` and at least one VC is eligible, select a VC, latch it into `cur_vc`, and accept the beat as the head flit.
    - If `pay_last` is also set, emit head=tail=1 and stay IDLE.
    - Otherwise go to SEND.
  - SEND: accept a beat only if `credit[cur_vc]>0`; emit head=0, tail=`pay_last`. After the tail, return to IDLE and clear `cur_vc`.
- VC eligibility:
  - NONATOMIC: credit>0.
  - ATOMIC: credit==B, meaning the downstream buffer is empty.
- VC selection is round-robin, starting one above the last granted VC. It resets to begin at VC0.
- `pay_ready` is combinational from registered state only: (IDLE & any eligible) | (SEND & `credit[cur_vc]`>0). It never depends on `pay_valid`.
- Credit arithmetic, each cycle per VC:
  - cnt += `credit_in[v]` − (flit accepted on v).
  - A simultaneous return and send on the same VC leaves the count unchanged.
- Only one packet is in flight at a time. No VC interleaving.

## Timing
- Accepted beat at edge N: `flit_out`/`flit_out_we` are registered and valid in cycle N+1. `flit_out_we` is high for exactly one cycle per accepted beat.
- Back-to-back beats produce one flit per cycle while credits last.
- Credit returned in cycle N can enable `pay_ready` in cycle N+1.
- Credits exhausted mid-packet: `pay_ready` goes low, the FSM holds SEND, and no flit is emitted. `flit_out` keeps its last value with `flit_out_we`=0.
- Reset, including mid-packet: all outputs go to 0, counters to B, state to IDLE, round-robin pointer to VC0. The partial packet is dropped; upstream must reset together.

## Configuration
- `NI_INJ_CREDIT_CHK_EN`: when defined, the block adds a sticky `credit_err` output, cleared only by reset. It is set when a counter would exceed B (credit_in while cnt==B) or go below 0.
- Without the macro there is no `credit_err` port and the check logic is absent. Counters saturate silently at B.

## Structure
- Package `ni_inj_pkg`:
  - log2 function.
  - Flit field offset constants: HEAD_BIT, TAIL_BIT, VC_LSB.
  - FSM state typedef (IDLE, SEND).
- Sub-module `ni_vc_rr_arbiter`: V-input round-robin one-hot arbiter with a priority register, updated only on a head grant.
- Top contains the FSM, credit counters and the output flit register.

## Test plan
- After reset, with B=4, V=4: send a 3-beat packet with payloads 0xA, 0xB, 0xC and no credit returns.
  - Flits appear on VC0 with head/body/tail bits 10, 00, 01.
  - credit[0]=1 afterwards.
- Single-beat packet: one flit with head=tail=1. The FSM stays IDLE; the next packet goes on VC1 (round-robin).
- Send 6 beats on VC0 with no credits returned, NONATOMIC.
  - `pay_ready` drops after the 4th beat.
  - Return one credit: exactly one more flit appears, one cycle after acceptance.
- ATOMIC, VC0 at credit 3 and all other VCs at 4: new head is placed on VC1. With all VCs at credit<4, `pay_ready`=0 in IDLE.
- Same-cycle `credit_in[0]` and a VC0 send with cnt=2: cnt remains 2.
- Assert `reset` mid-packet, after 2 of 5 beats: next cycle `flit_out_we`=0, `busy`=0, all counters=4. With the macro enabled, a spurious `credit_in[2]` at cnt=4 sets `credit_err`.
